// File: rtl/pyr_downsample_2x2.sv
// Pyramid reducer: turns a raster pixel stream into a half-resolution raster
// stream. Each output pixel is the round-half-up mean of one 2x2 block.
module pyr_downsample_2x2 #(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done
);

  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int LB_D = IMG_W / 2;
  localparam int LBW  = (LB_D > 1) ? $clog2(LB_D) : 1;

  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [DATA_WIDTH-1:0] pair_reg;
  logic [DATA_WIDTH:0]   linebuf [LB_D];

  logic                  accept;
  logic                  x_last;
  logic                  y_last;
  logic                  load;
  logic                  lb_wr;
  logic [LBW-1:0]        lb_idx;
  logic [DATA_WIDTH:0]   psum;
  logic [DATA_WIDTH+1:0] rsum;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign x_last   = (x == XW'(IMG_W - 1));
  assign y_last   = (y == YW'(IMG_H - 1));
  assign load     = accept && x[0] && y[0];
  assign lb_wr    = accept && x[0] && !y[0];
  assign lb_idx   = LBW'(x >> 1);
  assign psum     = {1'b0, pair_reg} + {1'b0, in_data};
  // Max 4*(2^N-1)+2 still fits in N+2 bits, so the +2 rounding cannot overflow.
  assign rsum     = {1'b0, psum} + {1'b0, linebuf[lb_idx]} + (DATA_WIDTH+2)'(2);

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_reg <= '0;
    end else if (accept && !x[0]) begin
      pair_reg <= in_data;
    end
  end

  // Even rows fully rewrite every entry before odd rows read it, so no reset.
  always_ff @(posedge clk) begin
    if (lb_wr) begin
      linebuf[lb_idx] <= psum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= DATA_WIDTH'(rsum >> 2);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && x_last && y_last;
    end
  end

endmodule

// File: tb/tb_pyr_downsample_2x2.sv
// Scoreboard bench for pyr_downsample_2x2 on an 8x8 frame: frame-level block
// means are queued when a frame is issued; a monitor pops them on each transfer.
module tb_pyr_downsample_2x2;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          frame_done;

  pyr_downsample_2x2 #(.IMG_W(W), .IMG_H(H), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int frame[H][W];
  int ready_mode = 0;
  int stall_arm  = 0;
  int stall_cnt  = 0;
  int fd_count   = 0;
  int fd_expect  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: every 2x2 block of the frame, mean rounded half up, raster order.
  task automatic push_expected();
    for (int by = 0; by < H / 2; by++)
      for (int bx = 0; bx < W / 2; bx++) begin
        int s;
        s = frame[2*by][2*bx] + frame[2*by][2*bx+1] + frame[2*by+1][2*bx] + frame[2*by+1][2*bx+1];
        exp_q.push_back((s + 2) / 4);
      end
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = int'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input int npix, input int gap_pct);
    int i;
    int px;
    int py;
    logic acc;
    i = 0;
    while (i < npix) begin
      px = i % W;
      py = i / W;
      @(negedge clk);
      if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = DW'(frame[py][px]);
      end
      #4;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
        #1;
        if ((px % 2 == 1) && (py % 2 == 1)) chk("latency_out_valid", int'(out_valid), 1);
        chk("frame_done_timing", int'(frame_done), int'(i == W * H - 1));
        i++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (npix == W * H) fd_expect++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Downstream ready: always on, random, or a 5-cycle stall against a held output.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else if (stall_arm != 0 && out_valid) begin
        out_ready = 1'b0;
        stall_cnt = 4;
        stall_arm = 0;
      end else if (ready_mode != 0) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: samples 1 time unit before each rising edge.
  initial begin
    logic          held;
    logic [DW-1:0] held_data;
    logic          prev_fd;
    held    = 1'b0;
    held_data = '0;
    prev_fd = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        held    = 1'b0;
        prev_fd = 1'b0;
      end else begin
        if (frame_done) begin
          fd_count++;
          chk("frame_done_single_cycle", int'(prev_fd), 0);
        end
        prev_fd = frame_done;
        chk("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
        if (held) begin
          chk("hold_out_valid", int'(out_valid), 1);
          chk("hold_out_data", int'(out_data), int'(held_data));
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output actual %0d required none", out_data);
          end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(out_data) != e) begin
              errors++;
              $display("FAIL out_data actual %0d expected %0d", out_data, e);
            end
          end
          held = 1'b0;
        end else if (out_valid) begin
          held      = 1'b1;
          held_data = out_data;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual running required finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);

    // Constant 100 at full throughput.
    fill_const(100);
    push_expected();
    send_frame(W * H, 0);
    drain();

    // Known 4x2 pattern in the top-left corner, random elsewhere, random ready.
    fill_rand();
    frame[0][0] = 1; frame[0][1] = 2; frame[0][2] = 10; frame[0][3] = 10;
    frame[1][0] = 2; frame[1][1] = 2; frame[1][2] = 10; frame[1][3] = 11;
    ready_mode = 1;
    push_expected();
    send_frame(W * H, 0);
    drain();
    ready_mode = 0;

    // Saturation and zero extremes.
    fill_const(255);
    push_expected();
    send_frame(W * H, 0);
    fill_const(0);
    push_expected();
    send_frame(W * H, 0);
    drain();

    // Ramp with a 5-cycle downstream stall against a held output.
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) frame[r][c] = 8 * r + c;
    stall_arm = 1;
    push_expected();
    send_frame(W * H, 0);
    drain();
    chk("stall_consumed", stall_arm, 0);

    // Reset after 6 pixels; partial frame must produce nothing.
    fill_rand();
    send_frame(6, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fill_const(50);
    push_expected();
    send_frame(W * H, 0);
    drain();

    // Back-to-back random frames with input gaps and random ready.
    ready_mode = 1;
    fill_rand();
    push_expected();
    send_frame(W * H, 30);
    fill_rand();
    push_expected();
    send_frame(W * H, 30);
    drain();
    ready_mode = 0;

    chk("frame_done_count", fd_count, fd_expect);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
